max7219_receiver: RTL and testbench
===================================

MAX7219_RECEIVER -- requirements
Module: MAX7219_RECEIVER

Interface
REQ-001 Parameters: none; all sizes fixed by the MAX7219 16-bit serial frame.
REQ-002 CLK_IN  input  1  system clock; all state updates on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 CS  input  1  serial chip select from the transmitter; active low; asynchronous to CLK_IN.
REQ-005 CLK  input  1  serial clock from the transmitter; data is valid on its rising edge.
REQ-006 DIN  input  1  serial data; MSB (bit 15) first.
REQ-007 DIGITS  output  64  digit registers; digit k (address k+1) occupies bits [8k+7:8k].
REQ-008 DECODE  output  8  decode-mode register (address 9).
REQ-009 INTENSITY  output  4  intensity register (address 10), data[3:0].
REQ-010 SCAN_LIMIT  output  3  scan-limit register (address 11), data[2:0].
REQ-011 SHUTDOWN  output  1  1 = shutdown; written as ~data[0] at address 12.
REQ-012 TEST  output  1  display-test register (address 15), data[0].
REQ-013 WR_STB  output  1  one-cycle pulse per committed frame.
REQ-014 WR_ADDR  output  4  frame bits [11:8]; valid while WR_STB=1.
REQ-015 WR_DATA  output  8  frame bits [7:0]; valid while WR_STB=1.
REQ-016 ERR  output  1  one-cycle pulse when a frame ends with fewer than 16 bits.

Function
REQ-017 The block SHALL use a two-state FSM: IDLE (CS high) and SHIFT (CS low).
REQ-018 CS falling edge: go IDLE->SHIFT and clear the 5-bit bit counter and the 16-bit shift register.
REQ-019 In SHIFT, each CLK rising edge SHALL shift DIN in at bit 0 (shift left), and the bit counter SHALL increment and saturate at 16.
REQ-020 A CLK rising edge sampled while CS is high SHALL be ignored.
REQ-021 When a CLK rising edge and a CS falling edge are sampled in the same cycle, the counter is cleared and the bit is counted as bit 1.
REQ-022 CS rising edge: go SHIFT->IDLE; if the counter is 16, commit the last 16 bits shifted in (extra leading bits are discarded); if it is 0-15, pulse ERR and change no register.
REQ-023 Commit SHALL pulse WR_STB with WR_ADDR/WR_DATA, and update the addressed register in the same cycle.
REQ-024 Addresses 0 (no-op), 13 and 14 SHALL pulse WR_STB and leave all registers unchanged; word bits [15:12] are ignored.
REQ-025 Commit latency: register outputs and WR_STB become visible at the 3rd CLK_IN rising edge that samples CS high with SYNC_EN defined, and at the 1st such edge without it.
REQ-026 Correct operation SHALL be guaranteed when CLK_IN is at least 4x the CLK frequency and CLK high/low times each span at least 2 CLK_IN periods.

Reset
REQ-027 While RST=1: DIGITS=0, DECODE=0, INTENSITY=0, SCAN_LIMIT=0, SHUTDOWN=1, TEST=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, ERR=0, FSM=IDLE, counter=0, and synchronizer/edge registers preset to CS=1, CLK=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without WR_STB or ERR.
REQ-029 If CS is low when RST deasserts, a CS falling edge SHALL be detected and a new frame started.

Configuration
REQ-030 Macro MAX7219_RECEIVER_SYNC_EN defined: CS, CLK and DIN each pass through a two-flop synchronizer before edge detection (latency per REQ-025).
REQ-031 Macro MAX7219_RECEIVER_SYNC_EN undefined: inputs feed edge detection directly, with one register stage holding the previous value; the inputs must then be synchronous to CLK_IN.

Verification
REQ-032 Frame 0x0C01 after reset -> SHUTDOWN 1->0; WR_STB=1 once with WR_ADDR=0xC, WR_DATA=0x01.
REQ-033 Frames 0x0A07, then 0x0B05, then 0x0F01 -> INTENSITY=7, SCAN_LIMIT=5, TEST=1.
REQ-034 Frame 0x01BD, then 0x08FF -> DIGITS[7:0]=0xBD, DIGITS[63:56]=0xFF; other digits remain 0.
REQ-035 12-bit frame 0x0A3 -> ERR pulse, no WR_STB, INTENSITY unchanged; 20-bit frame 0xF0A09 -> commit 0x0A09, INTENSITY=9.
REQ-036 RST pulsed after 8 bits of 0x0C01 -> no WR_STB or ERR, SHUTDOWN=1; the next full 0x0C01 frame commits normally.
REQ-037 End-to-end with the existing MAX7219 transmitter (CLK_DIV=1, DATA=0x1A2B3C4D, DOT=0x55) -> after one full refresh cycle, DIGITS=0xA1B2C3D4 mapped per digit through the 7-segment table with DOT bits, DIGITS[7:0]=0xBD, INTENSITY=1, SCAN_LIMIT=7, SHUTDOWN=0.

Source files
------------

// File: rtl/max7219_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : max7219_receiver_if
// Description : Serial input lines and decoded register outputs of the
//               MAX7219 frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface max7219_receiver_if;
  logic        cs;
  logic        clk;
  logic        din;
  logic [63:0] digits;
  logic [7:0]  decode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown;
  logic        test;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        err;

  modport master (
    output cs, clk, din,
    input  digits, decode, intensity, scan_limit, shutdown, test,
    input  wr_stb, wr_addr, wr_data, err
  );

  modport slave (
    input  cs, clk, din,
    output digits, decode, intensity, scan_limit, shutdown, test,
    output wr_stb, wr_addr, wr_data, err
  );
endinterface
`default_nettype wire

// File: rtl/max7219_receiver.sv
`default_nettype none
// ============================================================================
// Module      : max7219_receiver
// Description : Receives 16-bit MAX7219 serial frames and maintains the
//               device register file. Define MAX7219_RECEIVER_SYNC_EN to add
//               two-flop synchronizers on CS, CLK and DIN.
// Revision    : 1.0 - initial release
// ============================================================================
module max7219_receiver (
  input  logic                      clk_in_i,
  input  logic                      rst_i,
  max7219_receiver_if.slave         bus_if
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic cs_s;
  logic clk_s;
  logic din_s;

`ifdef MAX7219_RECEIVER_SYNC_EN
  logic [1:0] cs_sync_q;
  logic [1:0] clk_sync_q;
  logic [1:0] din_sync_q;

  always_ff @(posedge clk_in_i) begin
    if (rst_i) begin
      cs_sync_q  <= 2'b11;
      clk_sync_q <= 2'b00;
      din_sync_q <= 2'b00;
    end else begin
      cs_sync_q  <= {cs_sync_q[0],  bus_if.cs};
      clk_sync_q <= {clk_sync_q[0], bus_if.clk};
      din_sync_q <= {din_sync_q[0], bus_if.din};
    end
  end

  assign cs_s  = cs_sync_q[1];
  assign clk_s = clk_sync_q[1];
  assign din_s = din_sync_q[1];
`else
  assign cs_s  = bus_if.cs;
  assign clk_s = bus_if.clk;
  assign din_s = bus_if.din;
`endif

  state_t      state_q;
  logic        cs_prev_q;
  logic        clk_prev_q;
  logic [4:0]  cnt_q;
  logic [15:0] sr_q;
  logic [63:0] digits_q;
  logic [7:0]  decode_q;
  logic [3:0]  intensity_q;
  logic [2:0]  scan_limit_q;
  logic        shutdown_q;
  logic        test_q;
  logic        wr_stb_q;
  logic [3:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        err_q;

  logic        cs_fall;
  logic        clk_rise;
  logic [2:0]  dig_idx;
  logic        unused_hi;

  assign cs_fall   = cs_prev_q & ~cs_s;
  assign clk_rise  = ~clk_prev_q & clk_s;
  // Address 8 wraps to index 7 through the 3-bit subtraction.
  assign dig_idx   = sr_q[10:8] - 3'd1;
  assign unused_hi = ^sr_q[15:12];

  always_ff @(posedge clk_in_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cs_prev_q    <= 1'b1;
      clk_prev_q   <= 1'b0;
      cnt_q        <= 5'd0;
      sr_q         <= 16'd0;
      digits_q     <= 64'd0;
      decode_q     <= 8'd0;
      intensity_q  <= 4'd0;
      scan_limit_q <= 3'd0;
      shutdown_q   <= 1'b1;
      test_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= 4'd0;
      wr_data_q    <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      cs_prev_q  <= cs_s;
      clk_prev_q <= clk_s;
      wr_stb_q   <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q <= ST_SHIFT;
            // A clock edge coinciding with the select edge is the first bit.
            if (clk_rise) begin
              cnt_q <= 5'd1;
              sr_q  <= {15'd0, din_s};
            end else begin
              cnt_q <= 5'd0;
              sr_q  <= 16'd0;
            end
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            state_q <= ST_IDLE;
            if (cnt_q == 5'd16) begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= sr_q[11:8];
              wr_data_q <= sr_q[7:0];
              case (sr_q[11:8])
                4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8: digits_q[{dig_idx, 3'b000} +: 8] <= sr_q[7:0];
                4'd9:  decode_q     <= sr_q[7:0];
                4'd10: intensity_q  <= sr_q[3:0];
                4'd11: scan_limit_q <= sr_q[2:0];
                4'd12: shutdown_q   <= ~sr_q[0];
                4'd15: test_q       <= sr_q[0];
                default: ;
              endcase
            end else begin
              err_q <= 1'b1;
            end
          end else if (clk_rise) begin
            sr_q <= {sr_q[14:0], din_s};
            if (cnt_q != 5'd16) begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.digits     = digits_q;
  assign bus_if.decode     = decode_q;
  assign bus_if.intensity  = intensity_q;
  assign bus_if.scan_limit = scan_limit_q;
  assign bus_if.shutdown   = shutdown_q;
  assign bus_if.test       = test_q;
  assign bus_if.wr_stb     = wr_stb_q;
  assign bus_if.wr_addr    = wr_addr_q;
  assign bus_if.wr_data    = wr_data_q;
  assign bus_if.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_max7219_receiver
// Description : Directed self-checking bench for max7219_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max7219_receiver;

`ifdef MAX7219_RECEIVER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  max7219_receiver_if bus_if ();

  max7219_receiver dut (
    .clk_in_i (clk),
    .rst_i    (rst),
    .bus_if   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_total = 0;
  int err_total = 0;
  logic [3:0] last_addr = 4'd0;
  logic [7:0] last_data = 8'd0;

  always @(negedge clk) begin
    if (bus_if.wr_stb === 1'b1) begin
      stb_total = stb_total + 1;
      last_addr = bus_if.wr_addr;
      last_data = bus_if.wr_data;
    end
    if (bus_if.err === 1'b1) err_total = err_total + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts word[hi:lo], MSB first, with two-cycle low and high clock phases.
  task automatic shift_bits(input logic [31:0] word, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus_if.clk = 1'b0;
      bus_if.din = word[i];
      cycles(2);
      bus_if.clk = 1'b1;
      cycles(2);
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, input bit joined);
    if (joined) begin
      bus_if.din = word[nbits-1];
      bus_if.cs  = 1'b0;
      bus_if.clk = 1'b1;
      cycles(2);
      shift_bits(word, nbits - 2, 0);
    end else begin
      bus_if.cs = 1'b0;
      cycles(2);
      shift_bits(word, nbits - 1, 0);
    end
    bus_if.clk = 1'b0;
    cycles(2);
    bus_if.cs = 1'b1;
  endtask

  task automatic frame(input logic [31:0] word, input int nbits);
    send_frame(word, nbits, 1'b0);
    cycles(LAT + 3);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.cs = 1'b1; bus_if.clk = 1'b0; bus_if.din = 1'b0;
    cycles(3);
    n_checks++; if (bus_if.digits !== 64'd0) begin n_fail++; $display("FAIL reset_digits: got %h expected %h", bus_if.digits, 64'd0); end
    n_checks++; if (bus_if.decode !== 8'd0) begin n_fail++; $display("FAIL reset_decode: got %h expected 00", bus_if.decode); end
    n_checks++; if (bus_if.intensity !== 4'd0) begin n_fail++; $display("FAIL reset_intensity: got %h expected 0", bus_if.intensity); end
    n_checks++; if (bus_if.scan_limit !== 3'd0) begin n_fail++; $display("FAIL reset_scan_limit: got %h expected 0", bus_if.scan_limit); end
    n_checks++; if (bus_if.shutdown !== 1'b1) begin n_fail++; $display("FAIL reset_shutdown: got %b expected 1", bus_if.shutdown); end
    n_checks++; if (bus_if.test !== 1'b0) begin n_fail++; $display("FAIL reset_test: got %b expected 0", bus_if.test); end
    n_checks++; if ({bus_if.wr_stb, bus_if.err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {bus_if.wr_stb, bus_if.err}); end
    n_checks++; if ({bus_if.wr_addr, bus_if.wr_data} !== 12'h000) begin n_fail++; $display("FAIL reset_wr_bus: got %h expected 000", {bus_if.wr_addr, bus_if.wr_data}); end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_shutdown;
    int s0;
    s0 = stb_total;
    send_frame(32'h0C01, 16, 1'b0);
    cycles(LAT);
    n_checks++; if (bus_if.wr_stb !== 1'b1) begin n_fail++; $display("FAIL commit_latency: wr_stb got %b expected 1", bus_if.wr_stb); end
    n_checks++; if ({bus_if.wr_addr, bus_if.wr_data} !== 12'hC01) begin n_fail++; $display("FAIL commit_bus: got %h expected C01", {bus_if.wr_addr, bus_if.wr_data}); end
    n_checks++; if (bus_if.shutdown !== 1'b0) begin n_fail++; $display("FAIL shutdown_clear: got %b expected 0", bus_if.shutdown); end
    cycles(3);
    n_checks++; if (stb_total - s0 !== 1) begin n_fail++; $display("FAIL shutdown_stb_count: got %0d expected 1", stb_total - s0); end
  endtask

  task automatic test_control;
    frame(32'h0A07, 16);
    frame(32'h0B05, 16);
    frame(32'h0F01, 16);
    n_checks++; if (bus_if.intensity !== 4'd7) begin n_fail++; $display("FAIL ctrl_intensity: got %h expected 7", bus_if.intensity); end
    n_checks++; if (bus_if.scan_limit !== 3'd5) begin n_fail++; $display("FAIL ctrl_scan_limit: got %h expected 5", bus_if.scan_limit); end
    n_checks++; if (bus_if.test !== 1'b1) begin n_fail++; $display("FAIL ctrl_test: got %b expected 1", bus_if.test); end
  endtask

  task automatic test_digits;
    frame(32'h01BD, 16);
    frame(32'h08FF, 16);
    n_checks++; if (bus_if.digits !== 64'hFF00_0000_0000_00BD) begin n_fail++; $display("FAIL digits: got %h expected ff000000000000bd", bus_if.digits); end
  endtask

  task automatic test_noop_addr;
    int s0;
    s0 = stb_total;
    frame(32'h0D55, 16);
    frame(32'h0E66, 16);
    frame(32'h0000, 16);
    n_checks++; if (stb_total - s0 !== 3) begin n_fail++; $display("FAIL noop_stb_count: got %0d expected 3", stb_total - s0); end
    n_checks++; if (bus_if.digits !== 64'hFF00_0000_0000_00BD) begin n_fail++; $display("FAIL noop_digits: got %h expected ff000000000000bd", bus_if.digits); end
    n_checks++; if ({bus_if.decode, bus_if.intensity, bus_if.scan_limit, bus_if.shutdown, bus_if.test} !== {8'h00, 4'd7, 3'd5, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL noop_regs: got %h expected %h", {bus_if.decode, bus_if.intensity, bus_if.scan_limit, bus_if.shutdown, bus_if.test}, {8'h00, 4'd7, 3'd5, 1'b0, 1'b1});
    end
    frame(32'hF9AA, 16);
    n_checks++; if (bus_if.decode !== 8'hAA) begin n_fail++; $display("FAIL decode_upper_ignored: got %h expected aa", bus_if.decode); end
    n_checks++; if ({last_addr, last_data} !== 12'h9AA) begin n_fail++; $display("FAIL decode_wr_bus: got %h expected 9aa", {last_addr, last_data}); end
  endtask

  task automatic test_short_frame;
    int s0, e0;
    s0 = stb_total; e0 = err_total;
    frame(32'h0A3, 12);
    n_checks++; if (err_total - e0 !== 1) begin n_fail++; $display("FAIL short_err: got %0d expected 1", err_total - e0); end
    n_checks++; if (stb_total - s0 !== 0) begin n_fail++; $display("FAIL short_stb: got %0d expected 0", stb_total - s0); end
    n_checks++; if (bus_if.intensity !== 4'd7) begin n_fail++; $display("FAIL short_intensity: got %h expected 7", bus_if.intensity); end
  endtask

  task automatic test_long_frame;
    int s0, e0;
    s0 = stb_total; e0 = err_total;
    frame(32'hF0A09, 20);
    n_checks++; if (stb_total - s0 !== 1 || err_total - e0 !== 0) begin n_fail++; $display("FAIL long_pulses: got stb %0d err %0d expected 1 0", stb_total - s0, err_total - e0); end
    n_checks++; if ({last_addr, last_data} !== 12'hA09) begin n_fail++; $display("FAIL long_wr_bus: got %h expected a09", {last_addr, last_data}); end
    n_checks++; if (bus_if.intensity !== 4'd9) begin n_fail++; $display("FAIL long_intensity: got %h expected 9", bus_if.intensity); end
  endtask

  task automatic test_joined_edge;
    int e0;
    e0 = err_total;
    send_frame(32'h0A05, 16, 1'b1);
    cycles(LAT + 3);
    n_checks++; if (err_total - e0 !== 0) begin n_fail++; $display("FAIL joined_err: got %0d expected 0", err_total - e0); end
    n_checks++; if (bus_if.intensity !== 4'd5) begin n_fail++; $display("FAIL joined_intensity: got %h expected 5", bus_if.intensity); end
  endtask

  task automatic test_reset_midframe;
    int s0, e0;
    s0 = stb_total; e0 = err_total;
    bus_if.cs = 1'b0;
    cycles(2);
    shift_bits(32'h0C01, 15, 8);
    rst = 1'b1;
    cycles(2);
    bus_if.clk = 1'b0;
    bus_if.cs  = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(LAT + 3);
    n_checks++; if (stb_total - s0 !== 0 || err_total - e0 !== 0) begin n_fail++; $display("FAIL midrst_pulses: got stb %0d err %0d expected 0 0", stb_total - s0, err_total - e0); end
    n_checks++; if (bus_if.shutdown !== 1'b1) begin n_fail++; $display("FAIL midrst_shutdown: got %b expected 1", bus_if.shutdown); end
    n_checks++; if (bus_if.intensity !== 4'd0) begin n_fail++; $display("FAIL midrst_intensity: got %h expected 0", bus_if.intensity); end
    frame(32'h0C01, 16);
    n_checks++; if (bus_if.shutdown !== 1'b0 || stb_total - s0 !== 1) begin n_fail++; $display("FAIL midrst_recover: got shutdown %b stb %0d expected 0 1", bus_if.shutdown, stb_total - s0); end
  endtask

  task automatic test_cs_low_at_reset;
    int s0;
    rst = 1'b1;
    bus_if.cs  = 1'b0;
    bus_if.clk = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(4);
    s0 = stb_total;
    shift_bits(32'h0A03, 15, 0);
    bus_if.clk = 1'b0;
    cycles(2);
    bus_if.cs = 1'b1;
    cycles(LAT + 3);
    n_checks++; if (stb_total - s0 !== 1) begin n_fail++; $display("FAIL cslow_stb: got %0d expected 1", stb_total - s0); end
    n_checks++; if (bus_if.intensity !== 4'd3) begin n_fail++; $display("FAIL cslow_intensity: got %h expected 3", bus_if.intensity); end
  endtask

  initial begin
    bus_if.cs  = 1'b1;
    bus_if.clk = 1'b0;
    bus_if.din = 1'b0;
    test_reset();
    test_shutdown();
    test_control();
    test_digits();
    test_noop_addr();
    test_short_frame();
    test_long_frame();
    test_joined_edge();
    test_reset_midframe();
    test_cs_low_at_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
